fetch_queue_stage: RTL and testbench
====================================

Name: fetch_queue_stage

Overview:
- Pipelined instruction-fetch front end: owns the PC, reads the word-addressable instruction ROM, and buffers fetched words in a small FIFO.
- Feeds the decode/control stage through a valid/ready handshake.
- Accepts PC redirects (jump/branch) from downstream and flushes all wrong-path words.
- Decouples fetch from decode stalls without losing throughput.

Parameters:
- PC_W, 30, word-address PC width.
- IMEM_AW, 8, ROM address bits driven (low bits of the PC).
- DEPTH, 2, queue entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  IMEM_AW  ROM word address; equals pc[IMEM_AW-1:0].
- imem_data  in  32  ROM read data; combinational, valid in the same cycle as imem_addr.
- redirect_valid  in  1  load a new PC and flush the queue.
- redirect_pc  in  PC_W  new word-address PC.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  consumer accepts the head this cycle.
- out_instr  out  32  head instruction word.
- out_pc_seq  out  PC_W  head instruction's PC + 1, used by downstream branch/jump target math.

Behaviour:
- Reset (async, active-low): pc=0, count=0, rd_ptr=0, wr_ptr=0, all entries 0.
  - Outputs during reset: out_valid=0, out_instr=0, out_pc_seq=0, imem_addr=0.
- Reset may assert at any point, including mid-stream; all state clears immediately with no partial entries left behind.
- State: pc, circular buffer of DEPTH entries {instr[31:0], pc_seq[PC_W-1:0]}, rd_ptr/wr_ptr (log2 DEPTH bits, wrap naturally), count (0..DEPTH).
- Definitions:
  - pop = out_valid & out_ready.
  - push = (count < DEPTH) & ~redirect_valid.
  - push is computed from the count at the start of the cycle. A simultaneous pop does not enable a push when full; when count < DEPTH, push and pop in the same cycle are both allowed.
- Push (rising edge):
  - entry[wr_ptr] = {imem_data, pc+1}.
  - wr_ptr += 1.
  - pc = pc+1, with modulo-2^PC_W wrap: all-ones goes to 0.
- Pop (rising edge): rd_ptr += 1.
- count update: count += push - pop.
- Redirect (highest priority, rising edge):
  - pc = redirect_pc; count=0; rd_ptr=wr_ptr=0; no push that cycle.
  - A pop that handshakes in the same cycle is considered completed; the consumer owns that word.
  - Next cycle: out_valid=0, imem_addr=redirect_pc low bits.
  - The following edge pushes the target word; out_valid=1 two edges after the redirect edge.
- Outputs:
  - out_valid = (count != 0).
  - out_instr and out_pc_seq = entry[rd_ptr].
  - All outputs are derived purely from registered state. No combinational path from out_ready or redirect_* to any output.
- Latency: a word fetched at edge N appears at out_* after edge N when the queue was empty (1 cycle).
- Throughput: with out_ready held 1, one instruction per cycle; steady-state count=1.
- Full (count=DEPTH): pc and imem_addr hold; ROM is not sampled.
- Empty: out_instr/out_pc_seq show stale entry contents; consumer must ignore them when out_valid=0.
- out_valid/out_instr are stable while out_valid=1 and out_ready=0 (no redirect).
- No X propagation: unused entries hold reset or previously written data.

Test Plan:
- Reset release with ROM words[i]=0x1000_0000+i, out_ready=1 → out_valid=1 after first edge with out_instr=0x10000000, out_pc_seq=1; then 0x10000001, 0x10000002 on consecutive cycles; no bubbles.
- out_ready=0 for 5 cycles after 1st word → count reaches 2; pc holds at 2; out_instr stays 0x10000000. Release out_ready → 0x10000000, 0x10000001, 0x10000002 delivered back-to-back, no duplicates or drops.
- Queue full, redirect_valid=1 with redirect_pc=0x20 → next cycle out_valid=0, imem_addr=0x20. Following cycle out_instr=word[0x20], out_pc_seq=0x21; wrong-path words never appear.
- Redirect and pop in the same cycle → popped word counted delivered once; next delivered word is the target word; no extra word.
- Redirect to pc=2^30-1 with ROM index 0xFF valid → out_pc_seq=0; next fetch is from address 0.
- Assert rst_n=0 mid-stream with count=2 → out_valid=0 immediately (async); after release, fetching restarts at pc=0 with word[0].

Source files
------------

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch front end: owns the PC, reads the word-addressed ROM and
// buffers fetched words in a small circular queue feeding decode.
module fetch_queue_stage #(
    parameter int PC_W    = 30,
    parameter int IMEM_AW = 8,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [PC_W-1:0]    out_pc_seq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_inc;
    logic [31:0]      instr_mem [DEPTH];
    logic [PC_W-1:0]  seq_mem   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Handshake: a word transfers on a rising edge where out_valid and
    // out_ready are both high; out_valid never depends on out_ready, and the
    // head word holds until it transfers or a redirect flushes the queue.
    assign pop    = out_valid & out_ready;
    assign push   = (count < FULL_CNT) & ~redirect_valid;
    assign pc_inc = pc + PC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                seq_mem[i]   <= '0;
            end
        end else if (redirect_valid) begin
            // A pop handshaking this cycle is already owned by the consumer.
            pc     <= redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= imem_data;
                seq_mem[wr_ptr]   <= pc_inc;
                wr_ptr            <= wr_ptr + PTR_W'(1);
                pc                <= pc_inc;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign imem_addr  = pc[IMEM_AW-1:0];
    assign out_valid  = (count != '0);
    assign out_instr  = instr_mem[rd_ptr];
    assign out_pc_seq = seq_mem[rd_ptr];

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: cycle vectors for visible state plus an
// ordered scoreboard of the words the consumer should receive.
module tb_fetch_queue_stage;

    logic        clk;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [29:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [29:0] out_pc_seq;

    int n_checks  = 0;
    int n_pass    = 0;
    int delivered = 0;

    logic [61:0] exp_q[$];
    logic [61:0] sb_exp;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [29:0] rpc;
        logic        chk;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [29:0] e_seq;
        logic [7:0]  e_addr;
    } vec_t;

    vec_t vecs[26];

    fetch_queue_stage #(.PC_W(30), .IMEM_AW(8), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc_seq     (out_pc_seq)
    );

    // ROM: word i holds 0x1000_0000 + i
    assign imem_data = 32'h1000_0000 | {24'h0, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected delivery stream starting at word address t.
    task automatic push_stream(input logic [29:0] t);
        logic [29:0] a;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            a = t + 30'(i);
            exp_q.push_back({32'h1000_0000 | {24'h0, a[7:0]}, a + 30'd1});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            delivered++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_extra: got %h expected no word", {out_instr, out_pc_seq});
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_word", {2'b0, out_instr, out_pc_seq}, {2'b0, sb_exp});
            end
        end
    end

    task automatic do_reset(input int idx);
        rst_n = 1'b0;
        #1;
        check($sformatf("rst%0d_valid", idx), {63'b0, out_valid}, 64'd0);
        check($sformatf("rst%0d_addr", idx), {56'b0, imem_addr}, 64'd0);
        check($sformatf("rst%0d_instr", idx), {32'b0, out_instr}, 64'd0);
        check($sformatf("rst%0d_seq", idx), {34'b0, out_pc_seq}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_stream(30'd0);
    endtask

    function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                                input logic [29:0] rpc, input logic chk, input logic ev,
                                input logic [31:0] ei, input logic [29:0] es,
                                input logic [7:0] ea);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.chk = chk;
        v.e_valid = ev; v.e_instr = ei; v.e_seq = es; v.e_addr = ea;
        return v;
    endfunction

    initial begin
        rst_n          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // streaming from reset, no bubbles
        vecs[0]  = mk(1, 1, 0, 0, 1, 1, 32'h1000_0000, 30'd1, 8'd1);
        vecs[1]  = mk(0, 1, 0, 0, 1, 1, 32'h1000_0001, 30'd2, 8'd2);
        vecs[2]  = mk(0, 1, 0, 0, 1, 1, 32'h1000_0002, 30'd3, 8'd3);
        vecs[3]  = mk(0, 1, 0, 0, 1, 1, 32'h1000_0003, 30'd4, 8'd4);
        // stall fills the queue, pc holds, then drain back-to-back
        vecs[4]  = mk(1, 0, 0, 0, 1, 1, 32'h1000_0000, 30'd1, 8'd1);
        vecs[5]  = mk(0, 0, 0, 0, 1, 1, 32'h1000_0000, 30'd1, 8'd2);
        vecs[6]  = mk(0, 0, 0, 0, 1, 1, 32'h1000_0000, 30'd1, 8'd2);
        vecs[7]  = mk(0, 0, 0, 0, 1, 1, 32'h1000_0000, 30'd1, 8'd2);
        vecs[8]  = mk(0, 0, 0, 0, 1, 1, 32'h1000_0000, 30'd1, 8'd2);
        vecs[9]  = mk(0, 0, 0, 0, 1, 1, 32'h1000_0000, 30'd1, 8'd2);
        vecs[10] = mk(0, 1, 0, 0, 1, 1, 32'h1000_0001, 30'd2, 8'd2);
        vecs[11] = mk(0, 1, 0, 0, 1, 1, 32'h1000_0002, 30'd3, 8'd3);
        vecs[12] = mk(0, 1, 0, 0, 1, 1, 32'h1000_0003, 30'd4, 8'd4);
        // full queue, redirect to 0x20
        vecs[13] = mk(0, 0, 0, 0, 1, 1, 32'h1000_0003, 30'd4, 8'd5);
        vecs[14] = mk(0, 0, 1, 30'h20, 0, 0, 32'h0, 30'd0, 8'h20);
        vecs[15] = mk(0, 0, 0, 0, 1, 1, 32'h1000_0020, 30'h21, 8'h21);
        vecs[16] = mk(0, 1, 0, 0, 1, 1, 32'h1000_0021, 30'h22, 8'h22);
        // redirect with a same-cycle pop
        vecs[17] = mk(0, 1, 1, 30'h40, 0, 0, 32'h0, 30'd0, 8'h40);
        vecs[18] = mk(0, 1, 0, 0, 1, 1, 32'h1000_0040, 30'h41, 8'h41);
        vecs[19] = mk(0, 1, 0, 0, 1, 1, 32'h1000_0041, 30'h42, 8'h42);
        // redirect to the last PC, pc_seq wraps to 0
        vecs[20] = mk(0, 0, 1, 30'h3FFF_FFFF, 0, 0, 32'h0, 30'd0, 8'hFF);
        vecs[21] = mk(0, 0, 0, 0, 1, 1, 32'h1000_00FF, 30'd0, 8'h00);
        vecs[22] = mk(0, 1, 0, 0, 1, 1, 32'h1000_0000, 30'd1, 8'h01);
        // fill to two entries, then reset mid-stream
        vecs[23] = mk(0, 0, 0, 0, 1, 1, 32'h1000_0000, 30'd1, 8'h02);
        vecs[24] = mk(1, 1, 0, 0, 1, 1, 32'h1000_0000, 30'd1, 8'h01);
        vecs[25] = mk(0, 1, 0, 0, 1, 1, 32'h1000_0001, 30'd2, 8'h02);

        #1;
        for (int i = 0; i < 26; i++) begin
            if (vecs[i].rst) do_reset(i);
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(posedge clk);
            if (vecs[i].rv) push_stream(vecs[i].rpc);
            #1;
            check($sformatf("v%0d_valid", i), {63'b0, out_valid}, {63'b0, vecs[i].e_valid});
            check($sformatf("v%0d_addr", i), {56'b0, imem_addr}, {56'b0, vecs[i].e_addr});
            if (vecs[i].chk) begin
                check($sformatf("v%0d_instr", i), {32'b0, out_instr}, {32'b0, vecs[i].e_instr});
                check($sformatf("v%0d_seq", i), {34'b0, out_pc_seq}, {34'b0, vecs[i].e_seq});
            end
        end

        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("delivered_total", 64'(delivered), 64'd11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
